// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store sequencer.
// Op field layout, size codes, FSM states and byte-count helper.
package mem_access_pkg;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;
    localparam int OP_SZ_HI = 1;
    localparam int OP_SZ_LO = 0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction with sign/zero extension,
// and sub-word merge of store data into a read word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane; offset 0 is the most significant byte
    always_comb begin
        lane_b = word[31:24];
        case (offset)
            2'd0: lane_b = word[31:24];
            2'd1: lane_b = word[23:16];
            2'd2: lane_b = word[15:8];
            2'd3: lane_b = word[7:0];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[15:0] : word[31:16];
    end

    // Extend loads and merge store data into the untouched bytes
    always_comb begin
        rdata  = word;
        merged = word;
        case (size)
            SZ_BYTE: begin
                rdata = {{24{~uns & lane_b[7]}}, lane_b};
                case (offset)
                    2'd0: merged = {wdata[7:0], word[23:0]};
                    2'd1: merged = {word[31:24], wdata[7:0], word[15:0]};
                    2'd2: merged = {word[31:16], wdata[7:0], word[7:0]};
                    2'd3: merged = {word[31:8], wdata[7:0]};
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                rdata  = {{16{~uns & lane_h[15]}}, lane_h};
                merged = offset[1] ? {word[31:16], wdata}
                                   : {wdata, word[15:0]};
            end
            default: begin
                rdata  = word;
                merged = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time to a big-endian word memory.
// Optional range check enabled by defining MEM_ACCESS_RANGE_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] DataIn,
    output logic        RW,
    input  logic [31:0] DataOut
);

    state_t      state;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [1:0]  size_in;
    logic        misaligned;
    logic        range_err;
    logic        req_err;
    logic        accept;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    mem_lane_align u_align (
        .offset (off_q),
        .size   (op_q[OP_SZ_HI:OP_SZ_LO]),
        .uns    (op_q[OP_UNS]),
        .word   (DataOut),
        .wdata  (wdata_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    // Classify the incoming request before it is accepted
    always_comb begin
        size_in    = req_op[OP_SZ_HI:OP_SZ_LO];
        misaligned = ((size_in == SZ_HALF) && req_addr[0])
                   || ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        range_err  = ({1'b0, req_addr} + 33'(size_bytes(size_in)))
                   > 33'(MEM_BYTES);
`else
        range_err  = 1'b0;
`endif
        req_err    = (size_in == SZ_ILL) || misaligned || range_err;
        accept     = req_valid && req_ready;
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            address    <= '0;
            DataIn     <= '0;
            RW         <= 1'b0;
            op_q       <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_op[OP_STORE]
                                     && (size_in == SZ_WORD)) begin
                            state   <= ST_WRITE;
                            address <= {req_addr[31:2], 2'b00};
                            DataIn  <= req_wdata;
                            RW      <= 1'b1;
                        end else begin
                            state   <= ST_READ;
                            address <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_READ: begin
                    if (op_q[OP_STORE]) begin
                        state  <= ST_WRITE;
                        DataIn <= lane_merged;
                        RW     <= 1'b1;
                    end else begin
                        state      <= ST_RESP;
                        address    <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= lane_rdata;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    RW         <= 1'b0;
                    DataIn     <= '0;
                    address    <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-array memory model.
// Honours MEM_ACCESS_RANGE_CHECK_EN the same way as the design.
module tb_mem_access_unit;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_ILL = 4'b0011;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] DataIn;
    logic        RW;
    logic [31:0] DataOut;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .DataIn     (DataIn),
        .RW         (RW),
        .DataOut    (DataOut)
    );

    always #5 CLK = ~CLK;

    // Word memory seen by the DUT; contents wrap at 256 bytes
    logic [31:0] mem_w [64];
    logic        init;
    assign DataOut = mem_w[address[7:2]];

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899AABB;
        return 32'(i) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    always @(posedge CLK) begin
        if (init) begin
            for (int i = 0; i < 64; i++) mem_w[i] <= init_word(i);
        end else if (RW) begin
            mem_w[address[7:2]] <= DataIn;
        end
    end

    // Reference model: plain byte array, big-endian
    logic [7:0] mb [256];

    int n_chk  = 0;
    int n_fail = 0;

    bit          pending;
    int          cyc;
    int          rw_cnt;
    int          exp_lat;
    int          exp_rw;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [31:0] exp_din;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00: return 1;
            2'b01: return 2;
            2'b10: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic [1:0] sz,
                                     input logic [31:0] a);
        int n;
        n = nbytes(sz);
        if (n == 0) return 1'b1;
        if ((a % 32'(n)) != 0) return 1'b1;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        if (({32'd0, a} + 64'(n)) > 64'd256) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int bidx(input logic [31:0] a, input int i);
        return int'((a + 32'(i)) & 32'hFF);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a,
                                               input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = {v[23:0], mb[bidx(a, i)]};
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] wd);
        int n;
        logic [31:0] sh;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) begin
            sh = wd >> (8 * (n - 1 - i));
            mb[bidx(a, i)] = sh[7:0];
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mb[bidx(b, 0)], mb[bidx(b, 1)],
                mb[bidx(b, 2)], mb[bidx(b, 3)]};
    endfunction

    // One clock of observation: port invariants plus response checks
    task automatic tick();
        @(negedge CLK);
        if (!Reset) begin
            if (req_ready || resp_valid)
                chk("idle_port", {31'd0, RW} | address | DataIn, 32'd0);
            if (pending) begin
                cyc++;
                if (RW) begin
                    rw_cnt++;
                    chk("wr_addr", address, exp_addr);
                    chk("wr_data", DataIn, exp_din);
                end else if (!resp_valid) begin
                    chk("rd_addr", address, exp_addr);
                end
                if (resp_valid) begin
                    chk("latency", 32'(cyc), 32'(exp_lat));
                    chk("rdata", resp_rdata, exp_rdata);
                    chk("err", {31'd0, resp_err}, {31'd0, exp_err});
                    chk("rw_count", 32'(rw_cnt), 32'(exp_rw));
                    pending = 1'b0;
                end else if (cyc > 6) begin
                    chk("resp_timeout", 32'(cyc), 32'(exp_lat));
                    pending = 1'b0;
                end
            end else if (resp_valid) begin
                chk("spurious_resp", {31'd0, resp_valid}, 32'd0);
            end
        end
    endtask

    task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input bit pin,
                          input logic [31:0] pin_rdata,
                          input logic pin_err);
        int  w;
        bit  st;
        bit  e;
        w = 0;
        tick();
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            chk("ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        st        = op[3];
        e         = model_err(op[1:0], addr);
        exp_err   = e;
        exp_rdata = (e || st) ? 32'd0 : model_load(addr, op[1:0], op[2]);
        exp_lat   = e ? 1 : ((st && op[1:0] != 2'b10) ? 3 : 2);
        exp_rw    = (st && !e) ? 1 : 0;
        exp_addr  = e ? 32'd0 : {addr[31:2], 2'b00};
        exp_din   = 32'd0;
        if (st && !e) begin
            model_store(addr, op[1:0], wd);
            exp_din = model_word(addr);
        end
        if (pin) begin
            chk("pin_rdata", exp_rdata, pin_rdata);
            chk("pin_err", {31'd0, exp_err}, {31'd0, pin_err});
        end
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge CLK);
        pending = 1'b1;
        cyc     = 0;
        rw_cnt  = 0;
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        w = 0;
        while (pending && w < 10) begin
            tick();
            w++;
        end
        if (st && !e)
            chk("mem_word", mem_w[addr[7:2]], model_word(addr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic [31:0] pre;
        pending   = 1'b0;
        cyc       = 0;
        rw_cnt    = 0;
        Reset     = 1'b1;
        init      = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            w = init_word(i);
            mb[4*i]   = w[31:24];
            mb[4*i+1] = w[23:16];
            mb[4*i+2] = w[15:8];
            mb[4*i+3] = w[7:0];
        end
        repeat (2) @(posedge CLK);
        #1 init = 1'b0;
        @(negedge CLK);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp", {30'd0, resp_valid, resp_err} | resp_rdata, 32'd0);
        chk("reset_port", {31'd0, RW} | address | DataIn, 32'd0);
        Reset = 1'b0;

        do_req(OP_LB,  32'h11, 32'h0, 1'b1, 32'hFFFFFF99, 1'b0);
        do_req(OP_LHU, 32'h12, 32'h0, 1'b1, 32'h0000AABB, 1'b0);
        do_req(OP_LH,  32'h10, 32'h0, 1'b1, 32'hFFFF8899, 1'b0);
        do_req(OP_LW,  32'h10, 32'h0, 1'b1, 32'h8899AABB, 1'b0);
        do_req(OP_SB,  32'h13, 32'h123456CC, 1'b1, 32'h0, 1'b0);
        chk("sb_word", mem_w[4], 32'h8899AACC);
        do_req(OP_SH,  32'h10, 32'h00001234, 1'b1, 32'h0, 1'b0);
        chk("sh_word", mem_w[4], 32'h1234AACC);
        do_req(OP_LH,  32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(OP_LW,  32'h12, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(OP_ILL, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);

        // Abort a sub-word store while it is still reading
        tick();
        pre       = mem_w[4];
        req_op    = OP_SB;
        req_addr  = 32'h10;
        req_wdata = 32'h000000EE;
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk("abort_rw", {31'd0, RW}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) tick();
        Reset = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("abort_no_rw", {31'd0, RW}, 32'd0);
        end
        chk("abort_mem", mem_w[4], pre);
        chk("abort_mem_lit", mem_w[4], 32'h1234AACC);

        do_req(OP_LW, 32'hFC, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        do_req(OP_LW, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req(OP_LH, 32'hFF,  32'h0, 1'b1, 32'h0, 1'b1);
`else
        do_req(OP_LW, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0);
        do_req(OP_LB, 32'hFF,  32'h0, 1'b0, 32'h0, 1'b0);
`endif

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            do_req(4'($urandom), a, $urandom, 1'b0, 32'h0, 1'b0);
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
